hash_load_ctrl: RTL and testbench
=================================

Name: hash_load_ctrl

Overview:
- Sequencer in front of the 256-bit hash-vector assembler.
- On a start pulse it reads HASH_LENGTH consecutive 32-bit words from a single-port SRAM, starting at a latched base address, and presents each word with its word index to the assembler.
- It gates the assembler enable, signals address_read_complete with the last word, waits for hash_vector_complete, then pulses done.

Parameters:
- HASH_LENGTH, 8, words per hash vector; word k lands at vector bits [32k+31:32k].
- ADDR_WIDTH, 8, SRAM word-address width.
- TIMEOUT_CYCLES, 16, WAIT_DONE watchdog limit; used only with HASH_LOAD_CTRL_TIMEOUT_EN.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle load request; honoured only in IDLE.
- base_address  in  ADDR_WIDTH  SRAM address of word 0; latched on accepted start.
- sram_read_enable  out  1  SRAM read strobe.
- sram_read_address  out  ADDR_WIDTH  SRAM word address.
- sram_read_data  in  32  SRAM data, valid exactly 1 cycle after the sram_read_enable cycle.
- hash_enable  out  1  assembler enable; low clears the assembler vector.
- hash_address  out  $clog2(HASH_LENGTH)  word index presented to the assembler.
- hash_data  out  32  word presented to the assembler.
- address_read_complete  out  1  last word presented; assembler freezes on the next edge.
- hash_vector_complete  in  1  assembler completion flag.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle completion pulse.
- error  out  1  sticky timeout flag; tied 0 without the macro.

Behaviour:
- Reset (reset=0, async): state=IDLE; every output 0 (hash_enable included, so the assembler clears); counters 0; base register 0.
- All outputs are registered; no combinational input-to-output paths.
- FSM states: IDLE, CLEAR, READ, DRAIN, WAIT_DONE, DONE.
- IDLE:
  - start=1 latches base_address and goes to CLEAR.
  - hash_enable holds its previous value, so a completed vector stays visible until the next start.
  - start in any other state is ignored; no queuing.
- CLEAR (1 cycle): hash_enable=0 to clear the assembler, then READ.
- READ (HASH_LENGTH cycles, k=0..HASH_LENGTH-1):
  - sram_read_enable=1, sram_read_address=base+k, modulo 2^ADDR_WIDTH (wraps, no error).
  - hash_enable=1 from the first READ cycle through DONE.
- Data pipeline: SRAM data for read k is registered onto hash_data, with hash_address=k, and is valid during cycle R+k+2, where R is the first READ cycle. Each word is held exactly one cycle.
- DRAIN (2 cycles): sram_read_enable=0; pipeline empties. address_read_complete is set in the same cycle the last word (k=HASH_LENGTH-1) is presented, so the assembler captures it.
- WAIT_DONE:
  - address_read_complete held 1.
  - On hash_vector_complete=1, go to DONE.
  - hash_vector_complete=1 seen before address_read_complete is asserted is ignored.
- DONE (1 cycle): done=1, address_read_complete cleared, then IDLE with hash_enable kept 1.
- Latency, start accepted at edge E0 (default HASH_LENGTH=8):
  - CLEAR in cycle 1; READ in cycles 2–9.
  - Words presented in cycles 4–11; address_read_complete rises in cycle 11.
  - Assembler flag rises in cycle 12; done in cycle 13.
- Reset mid-operation: immediate return to IDLE with all outputs 0; the partial vector is discarded because hash_enable=0.
- busy=1 from CLEAR through DONE inclusive.

Optional Feature:
- HASH_LOAD_CTRL_TIMEOUT_EN defined:
  - A counter runs in WAIT_DONE.
  - If TIMEOUT_CYCLES cycles elapse without hash_vector_complete, error is set and the FSM goes to DONE (done pulses).
  - error stays sticky until the next accepted start or reset.
- Macro undefined: no counter; WAIT_DONE waits indefinitely; error is constant 0.

Test Plan:
- Reset, then start with base=0x10, SRAM[0x10+k]=0xA0000000+k -> read addresses 0x10..0x17 in cycles 2–9; hash_address 0..7 with matching data in cycles 4–11; address_read_complete in cycle 11; done in cycle 13; assembler vector = {0xA0000007,…,0xA0000000}.
- base=0xFC -> read addresses 0xFC,0xFD,0xFE,0xFF,0x00,0x01,0x02,0x03; error stays 0.
- start re-pulsed in cycles 3 and 10 of an active load -> ignored; exactly one done; next start after DONE gives one CLEAR cycle with hash_enable=0.
- reset asserted in cycle 6 -> all outputs 0 asynchronously; next start gives a clean full load with correct vector.
- hash_vector_complete forced 1 during READ -> no early done; done only after the WAIT_DONE observation.
- Macro defined, TIMEOUT_CYCLES=16, hash_vector_complete held 0 -> error=1 and done pulse 16 cycles after WAIT_DONE entry; error clears on next start.

Source files
------------

// File: rtl/hash_load_ctrl.sv
// hash_load_ctrl: sequencer that streams HASH_LENGTH words from a
// single-port SRAM into the 256-bit hash-vector assembler, then waits for the
// assembler to report completion and pulses done.
// Optional feature macro: HASH_LOAD_CTRL_TIMEOUT_EN adds a WAIT_DONE watchdog
// that sets a sticky error flag and forces completion after TIMEOUT_CYCLES.
module hash_load_ctrl #(
   parameter int HASH_LENGTH    = 8,
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                           clock,
   input  logic                           reset,
   input  logic                           start,
   input  logic [ADDR_WIDTH-1:0]          base_address,
   output logic                           sram_read_enable,
   output logic [ADDR_WIDTH-1:0]          sram_read_address,
   input  logic [31:0]                    sram_read_data,
   output logic                           hash_enable,
   output logic [$clog2(HASH_LENGTH)-1:0] hash_address,
   output logic [31:0]                    hash_data,
   output logic                           address_read_complete,
   input  logic                           hash_vector_complete,
   output logic                           busy,
   output logic                           done,
   output logic                           error
);

   localparam int HA_W    = $clog2(HASH_LENGTH);
   localparam int CNT_MAX = (HASH_LENGTH > TIMEOUT_CYCLES) ? HASH_LENGTH : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX) + 1;

   localparam logic [CNT_W-1:0] LAST_WORD  = CNT_W'(HASH_LENGTH - 1);
   localparam logic [CNT_W-1:0] LAST_DRAIN = CNT_W'(1);
   localparam logic [HA_W-1:0]  LAST_IDX   = HA_W'(HASH_LENGTH - 1);
`ifdef HASH_LOAD_CTRL_TIMEOUT_EN
   localparam logic [CNT_W-1:0] LAST_WAIT  = CNT_W'(TIMEOUT_CYCLES - 1);
`endif

   typedef enum logic [2:0] {
      S_IDLE, S_CLEAR, S_READ, S_DRAIN, S_WAIT_DONE, S_DONE
   } state_t;

   state_t                 state_reg, state_next;
   logic [CNT_W-1:0]       cnt_reg, cnt_next;
   logic [ADDR_WIDTH-1:0]  base_reg;

   // one-stage pipeline tracking which read returns data this cycle
   logic                   pipe_valid_reg;
   logic [HA_W-1:0]        pipe_idx_reg;

   // next values of the registered outputs
   logic                   rd_en_next;
   logic [ADDR_WIDTH-1:0]  rd_addr_next;
   logic                   hash_en_next;
   logic                   arc_next;
   logic                   busy_next;
   logic                   done_next;

`ifdef HASH_LOAD_CTRL_TIMEOUT_EN
   logic                   timeout_hit;
   logic                   error_reg;
`endif

   // state register, phase counter and latched base address
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg <= S_IDLE;
         cnt_reg   <= '0;
         base_reg  <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         if (state_reg == S_IDLE && start)
            base_reg <= base_address;
      end
   end

   // next-state and counter sequencing
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
`ifdef HASH_LOAD_CTRL_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      unique case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_CLEAR;
               cnt_next   = '0;
            end
         end
         S_CLEAR: begin
            state_next = S_READ;
            cnt_next   = '0;
         end
         S_READ: begin
            if (cnt_reg == LAST_WORD) begin
               state_next = S_DRAIN;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_DRAIN: begin
            if (cnt_reg == LAST_DRAIN) begin
               state_next = S_WAIT_DONE;
               cnt_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         S_WAIT_DONE: begin
            if (hash_vector_complete) begin
               state_next = S_DONE;
               cnt_next   = '0;
            end
`ifdef HASH_LOAD_CTRL_TIMEOUT_EN
            else if (cnt_reg == LAST_WAIT) begin
               state_next  = S_DONE;
               cnt_next    = '0;
               timeout_hit = 1'b1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
`endif
         end
         S_DONE: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
         default: begin
            state_next = S_IDLE;
            cnt_next   = '0;
         end
      endcase
   end

   // output decode from the upcoming state so every output comes from a flop
   always_comb begin
      rd_en_next   = (state_next == S_READ);
      rd_addr_next = rd_en_next ? (base_reg + ADDR_WIDTH'(cnt_next)) : '0;
      busy_next    = (state_next != S_IDLE);
      done_next    = (state_next == S_DONE);
      unique case (state_next)
         S_IDLE:  hash_en_next = hash_enable;   // keep the finished vector visible
         S_CLEAR: hash_en_next = 1'b0;          // wipe the assembler before loading
         default: hash_en_next = 1'b1;
      endcase
      // raised alongside the last word, then held until DONE
      arc_next = (pipe_valid_reg && pipe_idx_reg == LAST_IDX) ||
                 (address_read_complete && state_next == S_WAIT_DONE);
   end

   // registered control outputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sram_read_enable      <= 1'b0;
         sram_read_address     <= '0;
         hash_enable           <= 1'b0;
         address_read_complete <= 1'b0;
         busy                  <= 1'b0;
         done                  <= 1'b0;
      end else begin
         sram_read_enable      <= rd_en_next;
         sram_read_address     <= rd_addr_next;
         hash_enable           <= hash_en_next;
         address_read_complete <= arc_next;
         busy                  <= busy_next;
         done                  <= done_next;
      end
   end

   // read-return pipeline: SRAM data arrives one cycle after the strobe
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pipe_valid_reg <= 1'b0;
         pipe_idx_reg   <= '0;
         hash_data      <= '0;
         hash_address   <= '0;
      end else begin
         pipe_valid_reg <= sram_read_enable;
         pipe_idx_reg   <= HA_W'(cnt_reg);
         if (pipe_valid_reg) begin
            hash_data    <= sram_read_data;
            hash_address <= pipe_idx_reg;
         end
      end
   end

`ifdef HASH_LOAD_CTRL_TIMEOUT_EN
   // sticky watchdog flag, cleared by the next accepted start
   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         error_reg <= 1'b0;
      else if (timeout_hit)
         error_reg <= 1'b1;
      else if (state_reg == S_IDLE && start)
         error_reg <= 1'b0;
   end

   assign error = error_reg;
`else
   assign error = 1'b0;
`endif

endmodule

// File: tb/tb_hash_load_ctrl.sv
// Testbench for hash_load_ctrl: SRAM and assembler models around the DUT,
// per-cycle expected timeline derived from the load schedule.
module tb_hash_load_ctrl;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  base_address;
   logic        sram_read_enable;
   logic [7:0]  sram_read_address;
   logic [31:0] sram_read_data;
   logic        hash_enable;
   logic [2:0]  hash_address;
   logic [31:0] hash_data;
   logic        address_read_complete;
   logic        hash_vector_complete;
   logic        busy;
   logic        done;
   logic        error;

   logic [31:0]  mem [256];
   logic [255:0] asm_vec;
   logic         asm_cmpl;
   logic         hvc_force;
   logic         hvc_allow;

   int n_vec = 0;
   int n_err = 0;

   hash_load_ctrl dut (
      .clock                 (clock),
      .reset                 (reset),
      .start                 (start),
      .base_address          (base_address),
      .sram_read_enable      (sram_read_enable),
      .sram_read_address     (sram_read_address),
      .sram_read_data        (sram_read_data),
      .hash_enable           (hash_enable),
      .hash_address          (hash_address),
      .hash_data             (hash_data),
      .address_read_complete (address_read_complete),
      .hash_vector_complete  (hash_vector_complete),
      .busy                  (busy),
      .done                  (done),
      .error                 (error)
   );

   always #5 clock = ~clock;

   // SRAM: one-cycle read latency, garbage when not strobed
   always @(posedge clock) begin
      if (sram_read_enable)
         sram_read_data <= mem[sram_read_address];
      else
         sram_read_data <= $urandom();
   end

   // assembler: clears while disabled, freezes after capturing the last word
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         asm_vec  <= '0;
         asm_cmpl <= 1'b0;
      end else if (!hash_enable) begin
         asm_vec  <= '0;
         asm_cmpl <= 1'b0;
      end else if (!asm_cmpl) begin
         asm_vec[int'(hash_address)*32 +: 32] <= hash_data;
         if (address_read_complete)
            asm_cmpl <= 1'b1;
      end
   end

   assign hash_vector_complete = hvc_force | (asm_cmpl & hvc_allow);

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, " busy"},  256'(busy), 256'(0));
      chk({tag, " rd_en"}, 256'(sram_read_enable), 256'(0));
      chk({tag, " rd_addr"}, 256'(sram_read_address), 256'(0));
      chk({tag, " hash_en"}, 256'(hash_enable), 256'(0));
      chk({tag, " hash_addr"}, 256'(hash_address), 256'(0));
      chk({tag, " hash_data"}, 256'(hash_data), 256'(0));
      chk({tag, " arc"},   256'(address_read_complete), 256'(0));
      chk({tag, " done"},  256'(done), 256'(0));
      chk({tag, " error"}, 256'(error), 256'(0));
   endtask

   function automatic logic [255:0] expected_vec(input logic [7:0] base);
      logic [255:0] v;
      logic [7:0]   a;
      v = '0;
      for (int k = 0; k < 8; k++) begin
         a = base + 8'(k);
         v[k*32 +: 32] = mem[a];
      end
      return v;
   endfunction

   // One full load; cycle c counts clocks after the accepting edge.
   // delay: extra cycles the assembler flag is withheld; tmo: flag never seen.
   task automatic do_load(input logic [7:0] base, input int delay, input bit extra,
                          input bit force_early, input bit tmo);
      int         d;
      logic [7:0] a;
      d = tmo ? 12 + 16 : 13 + delay;
      hvc_allow    = 1'b0;
      hvc_force    = 1'b0;
      base_address = base;
      start        = 1'b1;
      @(posedge clock); #1;
      start        = 1'b0;
      base_address = $urandom();
      for (int c = 1; c <= d + 1; c++) begin
         hvc_force = force_early && (c >= 2) && (c <= 9);
         if (!tmo && c == 12 + delay)
            hvc_allow = 1'b1;
         chk($sformatf("c%0d busy", c), 256'(busy), 256'(c <= d));
         chk($sformatf("c%0d rd_en", c), 256'(sram_read_enable), 256'(c >= 2 && c <= 9));
         if (c >= 2 && c <= 9) begin
            a = base + 8'(c - 2);
            chk($sformatf("c%0d rd_addr", c), 256'(sram_read_address), 256'(a));
         end
         chk($sformatf("c%0d hash_en", c), 256'(hash_enable), 256'(c >= 2));
         if (c >= 4 && c <= 11) begin
            a = base + 8'(c - 4);
            chk($sformatf("c%0d hash_addr", c), 256'(hash_address), 256'(c - 4));
            chk($sformatf("c%0d hash_data", c), 256'(hash_data), 256'(mem[a]));
         end
         chk($sformatf("c%0d arc", c), 256'(address_read_complete), 256'(c >= 11 && c < d));
         chk($sformatf("c%0d done", c), 256'(done), 256'(c == d));
         chk($sformatf("c%0d error", c), 256'(error), 256'(tmo && c >= d));
         start = extra && (c == 3 || c == 10);
         @(posedge clock); #1;
      end
      start     = 1'b0;
      hvc_force = 1'b0;
      chk($sformatf("vector base %0h", base), asm_vec, expected_vec(base));
      $display("load base=%02h delay=%0d extra=%0d force=%0d tmo=%0d done_cycle=%0d",
               base, delay, extra, force_early, tmo, d);
   endtask

   // Load interrupted by reset in cycle 6
   task automatic reset_mid_load(input logic [7:0] base);
      base_address = base;
      start        = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      for (int c = 1; c < 6; c++) begin
         @(posedge clock); #1;
      end
      reset = 1'b0;
      #1;
      chk_all_zero("midreset");
      @(posedge clock); #1;
      chk_all_zero("midreset held");
      reset = 1'b1;
      @(posedge clock); #1;
      chk({"postreset busy"}, 256'(busy), 256'(0));
      $display("reset asserted in cycle 6 of load base=%02h", base);
   endtask

   initial begin
      reset        = 1'b0;
      start        = 1'b0;
      base_address = '0;
      hvc_force    = 1'b0;
      hvc_allow    = 1'b0;
      for (int i = 0; i < 256; i++) mem[i] = $urandom();
      #2;
      chk_all_zero("reset");
      repeat (2) @(posedge clock);
      #1;
      reset = 1'b1;
      @(posedge clock); #1;
      chk_all_zero("idle");

      for (int k = 0; k < 8; k++) mem[8'h10 + k] = 32'hA000_0000 + 32'(k);
      do_load(8'h10, 0, 1'b0, 1'b0, 1'b0);
      chk("directed vector", asm_vec,
          {32'hA0000007, 32'hA0000006, 32'hA0000005, 32'hA0000004,
           32'hA0000003, 32'hA0000002, 32'hA0000001, 32'hA0000000});

      do_load(8'hFC, 0, 1'b0, 1'b0, 1'b0);
      do_load(8'h40, 2, 1'b1, 1'b0, 1'b0);
      do_load(8'h41, 0, 1'b0, 1'b1, 1'b0);
      reset_mid_load(8'h80);
      do_load(8'h80, 0, 1'b0, 1'b0, 1'b0);

      for (int i = 0; i < 6; i++) begin
         for (int j = 0; j < 256; j++) mem[j] = $urandom();
         do_load(8'($urandom()), int'($urandom_range(0, 5)), 1'($urandom()),
                 1'($urandom()), 1'b0);
      end

`ifdef HASH_LOAD_CTRL_TIMEOUT_EN
      do_load(8'h22, 0, 1'b0, 1'b0, 1'b1);
      do_load(8'h23, 1, 1'b0, 1'b0, 1'b0);
`endif

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
